// File: rtl/regfile_mp_scoreboard.sv
// Multi-ported register file with per-register busy scoreboard for the pipelined datapath.
// Two prioritized write ports, NUM_READ combinational read ports, optional same-cycle bypass.
module regfile_mp_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we0,
  input  logic [ADDR_WIDTH-1:0]          waddr0,
  input  logic [DATA_WIDTH-1:0]          wdata0,
  input  logic                           we1,
  input  logic [ADDR_WIDTH-1:0]          waddr1,
  input  logic [DATA_WIDTH-1:0]          wdata1,
  input  logic                           mark_en,
  input  logic [ADDR_WIDTH-1:0]          mark_addr,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
  output logic [NUM_READ-1:0]            rbusy,
  output logic                           any_busy
);

  logic [DATA_WIDTH-1:0] r_regs     [NUM_REGS];
  logic [NUM_REGS-1:0]   r_busy;
  logic [DATA_WIDTH-1:0] w_regs_nxt [NUM_REGS];
  logic [NUM_REGS-1:0]   w_busy_nxt;
  logic [NUM_REGS-1:0]   w_wr0_hit;
  logic [NUM_REGS-1:0]   w_wr1_hit;
  logic [NUM_REGS-1:0]   w_mark_hit;

  // One-hot decode; out-of-range addresses and a hardwired zero register never hit.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
    localparam bit LP_WRITABLE = !(ZERO_REG != 0 && gi == 0);
    assign w_wr0_hit[gi]  = LP_WRITABLE && we0     && (waddr0    == ADDR_WIDTH'(gi));
    assign w_wr1_hit[gi]  = LP_WRITABLE && we1     && (waddr1    == ADDR_WIDTH'(gi));
    assign w_mark_hit[gi] = LP_WRITABLE && mark_en && (mark_addr == ADDR_WIDTH'(gi));
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_regs_nxt[i] = r_regs[i];
      if (w_wr0_hit[i]) w_regs_nxt[i] = wdata0;
      if (w_wr1_hit[i]) w_regs_nxt[i] = wdata1;
    end
  end

  // A mark in the same cycle as a retiring write belongs to the newer producer, so it wins.
  assign w_busy_nxt = (r_busy & ~(w_wr0_hit | w_wr1_hit)) | w_mark_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= w_regs_nxt[i];
      r_busy <= w_busy_nxt;
    end
  end

  assign any_busy = |r_busy;

  for (genvar gk = 0; gk < NUM_READ; gk++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_busy;

    assign w_addr = raddr[gk*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      w_data = '0;
      w_busy = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_addr == ADDR_WIDTH'(i) && !(ZERO_REG != 0 && i == 0)) begin
          if (BYPASS != 0) begin
            w_data = w_regs_nxt[i];
            w_busy = w_busy_nxt[i];
          end else begin
            w_data = r_regs[i];
            w_busy = r_busy[i];
          end
        end
      end
    end

    assign rdata[gk*DATA_WIDTH +: DATA_WIDTH] = w_data;
    assign rbusy[gk]                          = w_busy;
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Bench for regfile_mp_scoreboard: two configurations share one stimulus stream and
// are checked against an array-based reference model.
module tb_regfile_mp_scoreboard;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, we0, we1, mark_en;
  logic [AW-1:0]      waddr0, waddr1, mark_addr;
  logic [DW-1:0]      wdata0, wdata1;
  logic [NRD*AW-1:0]  raddr;
  logic [NRD*DW-1:0]  rdata_a, rdata_b;
  logic [NRD-1:0]     rbusy_a, rbusy_b;
  logic               any_a, any_b;

  // inst 0: 24 regs, zero reg, bypass. inst 1: 32 regs, no zero reg, no bypass.
  regfile_mp_scoreboard #(.DATA_WIDTH(DW), .NUM_REGS(24), .ADDR_WIDTH(AW), .NUM_READ(NRD),
                          .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .mark_en(mark_en), .mark_addr(mark_addr),
    .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a), .any_busy(any_a));

  regfile_mp_scoreboard #(.DATA_WIDTH(DW), .NUM_REGS(32), .ADDR_WIDTH(AW), .NUM_READ(NRD),
                          .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .mark_en(mark_en), .mark_addr(mark_addr),
    .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b), .any_busy(any_b));

  int n_pass  = 0;
  int n_total = 0;

  logic [DW-1:0] m_regs [2][32];
  bit            m_busy [2][32];

  function automatic int nregs(int inst);
    return (inst == 0) ? 24 : 32;
  endfunction

  function automatic bit writable(int inst, int a);
    return (a < nregs(inst)) && !(inst == 0 && a == 0);
  endfunction

  function automatic logic [DW-1:0] got_d(int inst, int k);
    return (inst == 0) ? rdata_a[k*DW +: DW] : rdata_b[k*DW +: DW];
  endfunction

  function automatic logic got_b(int inst, int k);
    return (inst == 0) ? rbusy_a[k] : rbusy_b[k];
  endfunction

  function automatic logic got_any(int inst);
    return (inst == 0) ? any_a : any_b;
  endfunction

  function automatic logic [DW-1:0] exp_d(int inst, int k);
    int a;
    a = int'(raddr[k*AW +: AW]);
    if (!writable(inst, a)) return '0;
    if (inst == 0) begin
      if (we1 && int'(waddr1) == a) return wdata1;
      if (we0 && int'(waddr0) == a) return wdata0;
    end
    return m_regs[inst][a];
  endfunction

  function automatic logic exp_b(int inst, int k);
    int a;
    a = int'(raddr[k*AW +: AW]);
    if (!writable(inst, a)) return 1'b0;
    if (inst == 0) begin
      if (mark_en && int'(mark_addr) == a) return 1'b1;
      if ((we1 && int'(waddr1) == a) || (we0 && int'(waddr0) == a)) return 1'b0;
    end
    return m_busy[inst][a];
  endfunction

  function automatic logic exp_any(int inst);
    logic r;
    r = 1'b0;
    for (int i = 0; i < nregs(inst); i++) r = r | m_busy[inst][i];
    return r;
  endfunction

  // Clock edge: reference model follows the architectural rules in priority order.
  task automatic advance();
    @(posedge clk);
    for (int inst = 0; inst < 2; inst++) begin
      if (reset) begin
        for (int i = 0; i < 32; i++) begin
          m_regs[inst][i] = '0;
          m_busy[inst][i] = 1'b0;
        end
      end else begin
        if (we0 && writable(inst, int'(waddr0))) begin
          m_regs[inst][waddr0] = wdata0;
          m_busy[inst][waddr0] = 1'b0;
        end
        if (we1 && writable(inst, int'(waddr1))) begin
          m_regs[inst][waddr1] = wdata1;
          m_busy[inst][waddr1] = 1'b0;
        end
        if (mark_en && writable(inst, int'(mark_addr))) m_busy[inst][mark_addr] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_idle();
    reset = 1'b0; we0 = 1'b0; we1 = 1'b0; mark_en = 1'b0;
    waddr0 = '0; waddr1 = '0; mark_addr = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic set_raddr(int a0, int a1);
    raddr = {AW'(a1), AW'(a0)};
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    set_raddr(3, 7);
    advance();
    reset = 1'b0;
    #1;
    for (int inst = 0; inst < 2; inst++) begin
      for (int k = 0; k < NRD; k++) begin
        n_total++;
        if (got_d(inst, k) !== 32'h0)
          $display("FAIL reset_rdata inst%0d port%0d: got %h want 0", inst, k, got_d(inst, k));
        else n_pass++;
        n_total++;
        if (got_b(inst, k) !== 1'b0)
          $display("FAIL reset_rbusy inst%0d port%0d: got %b want 0", inst, k, got_b(inst, k));
        else n_pass++;
      end
      n_total++;
      if (got_any(inst) !== 1'b0)
        $display("FAIL reset_any_busy inst%0d: got %b want 0", inst, got_any(inst));
      else n_pass++;
    end
  endtask

  task automatic test_write_basic();
    set_idle();
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'hDEADBEEF;
    set_raddr(5, 5);
    #1;
    n_total++;
    if (got_d(1, 0) !== 32'h0)
      $display("FAIL basic_nobypass_same_cycle: got %h want 0", got_d(1, 0));
    else n_pass++;
    n_total++;
    if (got_d(0, 0) !== 32'hDEADBEEF)
      $display("FAIL basic_bypass_same_cycle: got %h want deadbeef", got_d(0, 0));
    else n_pass++;
    advance();
    set_idle();
    #1;
    for (int inst = 0; inst < 2; inst++) begin
      n_total++;
      if (got_d(inst, 0) !== 32'hDEADBEEF)
        $display("FAIL basic_next_cycle inst%0d: got %h want deadbeef", inst, got_d(inst, 0));
      else n_pass++;
    end
  endtask

  task automatic test_dual_write();
    set_idle();
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h22;
    set_raddr(9, 9);
    #1;
    n_total++;
    if (got_d(0, 1) !== 32'h22)
      $display("FAIL dual_bypass: got %h want 22", got_d(0, 1));
    else n_pass++;
    advance();
    set_idle();
    #1;
    for (int inst = 0; inst < 2; inst++) begin
      n_total++;
      if (got_d(inst, 1) !== 32'h22)
        $display("FAIL dual_stored inst%0d: got %h want 22", inst, got_d(inst, 1));
      else n_pass++;
    end
  endtask

  task automatic test_zero_reg();
    set_idle();
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
    mark_en = 1'b1; mark_addr = 5'd0;
    set_raddr(0, 0);
    #1;
    n_total++;
    if (got_d(0, 0) !== 32'h0 || got_b(0, 0) !== 1'b0)
      $display("FAIL zero_same_cycle: got %h/%b want 0/0", got_d(0, 0), got_b(0, 0));
    else n_pass++;
    advance();
    set_idle();
    #1;
    n_total++;
    if (got_d(0, 0) !== 32'h0 || got_b(0, 0) !== 1'b0 || got_any(0) !== 1'b0)
      $display("FAIL zero_after: got %h/%b/%b want 0/0/0", got_d(0, 0), got_b(0, 0), got_any(0));
    else n_pass++;
    n_total++;
    if (got_d(1, 0) !== 32'hFFFFFFFF || got_b(1, 0) !== 1'b1 || got_any(1) !== 1'b1)
      $display("FAIL reg0_writable: got %h/%b/%b want ffffffff/1/1",
               got_d(1, 0), got_b(1, 0), got_any(1));
    else n_pass++;
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h0;
    advance();
    set_idle();
  endtask

  task automatic test_scoreboard();
    set_idle();
    mark_en = 1'b1; mark_addr = 5'd12;
    set_raddr(12, 12);
    #1;
    n_total++;
    if (got_b(0, 0) !== 1'b1 || got_b(1, 0) !== 1'b0)
      $display("FAIL mark_same_cycle: got a=%b b=%b want a=1 b=0", got_b(0, 0), got_b(1, 0));
    else n_pass++;
    advance();
    set_idle();
    #1;
    for (int inst = 0; inst < 2; inst++) begin
      n_total++;
      if (got_b(inst, 0) !== 1'b1 || got_any(inst) !== 1'b1)
        $display("FAIL mark_stored inst%0d: got %b/%b want 1/1", inst, got_b(inst, 0), got_any(inst));
      else n_pass++;
    end
    we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h1234;
    mark_en = 1'b1; mark_addr = 5'd12;
    #1;
    n_total++;
    if (got_b(0, 1) !== 1'b1)
      $display("FAIL mark_wins_bypass: got %b want 1", got_b(0, 1));
    else n_pass++;
    advance();
    set_idle();
    mark_en = 1'b1; mark_addr = 5'd12;
    advance();
    set_idle();
    #1;
    for (int inst = 0; inst < 2; inst++) begin
      n_total++;
      if (got_b(inst, 0) !== 1'b1 || got_d(inst, 0) !== 32'h1234)
        $display("FAIL mark_wins_stored inst%0d: got %b/%h want 1/1234",
                 inst, got_b(inst, 0), got_d(inst, 0));
      else n_pass++;
    end
    we1 = 1'b1; waddr1 = 5'd12; wdata1 = 32'h55;
    #1;
    n_total++;
    if (got_b(0, 0) !== 1'b0 || got_b(1, 0) !== 1'b1)
      $display("FAIL clear_same_cycle: got a=%b b=%b want a=0 b=1", got_b(0, 0), got_b(1, 0));
    else n_pass++;
    advance();
    set_idle();
    #1;
    for (int inst = 0; inst < 2; inst++) begin
      n_total++;
      if (got_b(inst, 0) !== 1'b0 || got_any(inst) !== 1'b0)
        $display("FAIL clear_stored inst%0d: got %b/%b want 0/0", inst, got_b(inst, 0), got_any(inst));
      else n_pass++;
    end
  endtask

  task automatic test_out_of_range();
    set_idle();
    we1 = 1'b1; waddr1 = 5'd30; wdata1 = 32'h5;
    mark_en = 1'b1; mark_addr = 5'd30;
    set_raddr(30, 30);
    #1;
    n_total++;
    if (got_d(0, 0) !== 32'h0 || got_b(0, 0) !== 1'b0)
      $display("FAIL oor_same_cycle: got %h/%b want 0/0", got_d(0, 0), got_b(0, 0));
    else n_pass++;
    advance();
    set_idle();
    #1;
    n_total++;
    if (got_d(0, 0) !== 32'h0 || got_b(0, 0) !== 1'b0 || got_any(0) !== 1'b0)
      $display("FAIL oor_after: got %h/%b/%b want 0/0/0", got_d(0, 0), got_b(0, 0), got_any(0));
    else n_pass++;
    n_total++;
    if (got_d(1, 0) !== 32'h5 || got_b(1, 0) !== 1'b1)
      $display("FAIL inrange_32: got %h/%b want 5/1", got_d(1, 0), got_b(1, 0));
    else n_pass++;
    mark_en = 1'b1; mark_addr = 5'd20;
    set_raddr(30, 20);
    advance();
    set_idle();
    #1;
    n_total++;
    if (got_b(0, 1) !== 1'b1)
      $display("FAIL mark20: got %b want 1", got_b(0, 1));
    else n_pass++;
    reset = 1'b1;
    mark_en = 1'b1; mark_addr = 5'd21;
    we0 = 1'b1; waddr0 = 5'd21; wdata0 = 32'h77;
    advance();
    set_idle();
    set_raddr(21, 20);
    #1;
    for (int inst = 0; inst < 2; inst++) begin
      n_total++;
      if (got_b(inst, 1) !== 1'b0 || got_b(inst, 0) !== 1'b0 || got_any(inst) !== 1'b0 ||
          got_d(inst, 0) !== 32'h0)
        $display("FAIL reset_mid inst%0d: got busy20=%b busy21=%b any=%b d21=%h want 0/0/0/0",
                 inst, got_b(inst, 1), got_b(inst, 0), got_any(inst), got_d(inst, 0));
      else n_pass++;
    end
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 7))
      0: return 5'd0;
      1: return 5'd12;
      2: return 5'd23;
      3: return 5'd24;
      default: return AW'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic test_random();
    logic [AW-1:0] ra [NRD];
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset     = ($urandom_range(0, 49) == 0);
      we0       = 1'($urandom_range(0, 1));
      we1       = 1'($urandom_range(0, 1));
      mark_en   = 1'($urandom_range(0, 1));
      waddr0    = pick_addr();
      waddr1    = ($urandom_range(0, 3) == 0) ? waddr0 : pick_addr();
      mark_addr = ($urandom_range(0, 2) == 0) ? waddr0 : pick_addr();
      wdata0    = $urandom;
      wdata1    = $urandom;
      for (int k = 0; k < NRD; k++) begin
        case ($urandom_range(0, 4))
          0: ra[k] = waddr0;
          1: ra[k] = waddr1;
          2: ra[k] = mark_addr;
          default: ra[k] = pick_addr();
        endcase
      end
      set_raddr(int'(ra[0]), int'(ra[1]));
      #1;
      if (!reset) begin
        for (int inst = 0; inst < 2; inst++) begin
          for (int k = 0; k < NRD; k++) begin
            n_total++;
            if (got_d(inst, k) !== exp_d(inst, k))
              $display("FAIL rand_rdata cyc%0d inst%0d port%0d addr%0d: got %h want %h",
                       cyc, inst, k, ra[k], got_d(inst, k), exp_d(inst, k));
            else n_pass++;
            n_total++;
            if (got_b(inst, k) !== exp_b(inst, k))
              $display("FAIL rand_rbusy cyc%0d inst%0d port%0d addr%0d: got %b want %b",
                       cyc, inst, k, ra[k], got_b(inst, k), exp_b(inst, k));
            else n_pass++;
          end
          n_total++;
          if (got_any(inst) !== exp_any(inst))
            $display("FAIL rand_any_busy cyc%0d inst%0d: got %b want %b",
                     cyc, inst, got_any(inst), exp_any(inst));
          else n_pass++;
        end
      end
      advance();
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    set_raddr(0, 0);
    @(negedge clk);
    test_reset();
    test_write_basic();
    test_dual_write();
    test_zero_reg();
    test_scoreboard();
    test_out_of_range();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
